// File: rtl/csr_unit.sv
// csr_unit: Zicsr register file with NUM_CSR general CSRs and optional 64-bit mcycle/minstret.
// Each request is one atomic read-modify-write; the old value is returned one cycle later.
module csr_unit #(
  parameter int          NUM_CSR     = 8,
  parameter logic [11:0] CSR_BASE    = 12'h7C0,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [11:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_zimm,
  input  logic        req_src_zero,
  input  logic        retire,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_illegal
);

  logic [31:0] r_csr [NUM_CSR];
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [11:0] w_idx;
  logic        w_gen_sel;
  logic        w_cnt_sel;
  logic        w_f3_ok;
  logic        w_wr_intent;
  logic        w_ro;
  logic        w_illegal;
  logic        w_do_write;
  logic        w_wr_cyc;
  logic        w_wr_ins;
  logic [63:0] w_cnt64;
  logic [31:0] w_cnt_rdata;
  logic [31:0] w_gen_rdata;
  logic [31:0] w_old;
  logic [31:0] w_src;
  logic [31:0] w_new;

  // 13-bit compare so a bank ending at 0xFFF does not wrap the upper bound.
  assign w_idx     = req_addr - CSR_BASE;
  assign w_gen_sel = ({1'b0, req_addr} >= {1'b0, CSR_BASE}) &&
                     ({1'b0, req_addr} <  ({1'b0, CSR_BASE} + 13'(NUM_CSR)));

  // Counter map: page B (rw) or C (ro); addr[7] picks the high half, addr[1] picks minstret.
  assign w_cnt_sel = COUNTERS_EN &&
                     ((req_addr[11:8] == 4'hB) || (req_addr[11:8] == 4'hC)) &&
                     ((req_addr[6:0] == 7'h00) || (req_addr[6:0] == 7'h02));
  assign w_cnt64     = req_addr[1] ? r_minstret : r_mcycle;
  assign w_cnt_rdata = req_addr[7] ? w_cnt64[63:32] : w_cnt64[31:0];

  always_comb begin
    w_gen_rdata = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      if (w_idx == 12'(i)) w_gen_rdata = r_csr[i];
    end
  end

  assign w_old = w_gen_sel ? w_gen_rdata : (w_cnt_sel ? w_cnt_rdata : 32'h0);
  assign w_src = req_funct3[2] ? {27'b0, req_zimm} : req_rs1_data;

  always_comb begin
    case (req_funct3[1:0])
      2'b10:   w_new = w_old | w_src;
      2'b11:   w_new = w_old & ~w_src;
      default: w_new = w_src;
    endcase
  end

  assign w_f3_ok     = (req_funct3[1:0] != 2'b00);
  assign w_wr_intent = (req_funct3[1:0] == 2'b01) || !req_src_zero;
  assign w_ro        = (req_addr[11:10] == 2'b11);
  assign w_illegal   = !(w_gen_sel || w_cnt_sel) || !w_f3_ok || (w_ro && w_wr_intent);
  assign w_do_write  = req_valid && !w_illegal && w_wr_intent;
  assign w_wr_cyc    = w_do_write && w_cnt_sel && !req_addr[1];
  assign w_wr_ins    = w_do_write && w_cnt_sel && req_addr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CSR; i++) r_csr[i] <= '0;
    end else if (w_do_write && w_gen_sel) begin
      for (int i = 0; i < NUM_CSR; i++) begin
        if (w_idx == 12'(i)) r_csr[i] <= w_new;
      end
    end
  end

  // A software write to either half suppresses that counter's increment for the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wr_cyc) begin
        if (req_addr[7]) r_mcycle[63:32] <= w_new;
        else             r_mcycle[31:0]  <= w_new;
      end else begin
        r_mcycle <= r_mcycle + 64'd1;
      end
      if (w_wr_ins) begin
        if (req_addr[7]) r_minstret[63:32] <= w_new;
        else             r_minstret[31:0]  <= w_new;
      end else if (retire) begin
        r_minstret <= r_minstret + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      rsp_valid <= req_valid;
      if (req_valid) begin
        rsp_rdata   <= w_illegal ? 32'h0 : w_old;
        rsp_illegal <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed test-plan sequences plus randomized traffic, checked every cycle
// against a behavioural CSR/counter model.
module tb_csr_unit;

  localparam int          NUM_CSR  = 8;
  localparam logic [11:0] CSR_BASE = 12'h7C0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [11:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1_data = '0;
  logic [4:0]  req_zimm = '0;
  logic        req_src_zero = 1'b0;
  logic        retire = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  always #5 clk = ~clk;

  csr_unit #(.NUM_CSR(NUM_CSR), .CSR_BASE(CSR_BASE), .COUNTERS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rs1_data(req_rs1_data), .req_zimm(req_zimm),
    .req_src_zero(req_src_zero), .retire(retire), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal)
  );

  int tests = 0;
  int fails = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: CSRs as an array, counters as plain 64-bit integers.
  logic [31:0] m_gen [NUM_CSR];
  logic [63:0] m_cyc, m_ins, cyc_n, ins_n;
  logic        exp_valid, exp_ill;
  logic [31:0] exp_rdata, m_old, m_src, m_new;
  bit          m_legal, m_wr;

  function automatic bit is_gen(input logic [11:0] a);
    return (int'(a) >= int'(CSR_BASE)) && (int'(a) < int'(CSR_BASE) + NUM_CSR);
  endfunction

  function automatic bit is_cnt(input logic [11:0] a);
    return a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
  endfunction

  function automatic logic [31:0] cnt_read(input logic [11:0] a);
    case (a)
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      default:          return m_ins[63:32];
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CSR; i++) m_gen[i] = '0;
      m_cyc = '0; m_ins = '0;
      exp_valid = 0; exp_ill = 0; exp_rdata = '0;
    end else begin
      cyc_n = m_cyc + 64'd1;
      ins_n = m_ins + (retire ? 64'd1 : 64'd0);
      exp_valid = req_valid;
      if (req_valid) begin
        m_wr    = (req_funct3 == 3'b001) || (req_funct3 == 3'b101) || !req_src_zero;
        m_legal = (is_gen(req_addr) || is_cnt(req_addr)) &&
                  (req_funct3 inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111}) &&
                  !(req_addr >= 12'hC00 && m_wr);
        m_old = is_gen(req_addr) ? m_gen[int'(req_addr) - int'(CSR_BASE)]
              : (is_cnt(req_addr) ? cnt_read(req_addr) : 32'h0);
        m_src = req_funct3[2] ? 32'(req_zimm) : req_rs1_data;
        if (req_funct3[1:0] == 2'b01)      m_new = m_src;
        else if (req_funct3[1:0] == 2'b10) m_new = m_old | m_src;
        else                               m_new = m_old & ~m_src;
        exp_ill   = !m_legal;
        exp_rdata = m_legal ? m_old : 32'h0;
        if (m_legal && m_wr) begin
          if (is_gen(req_addr)) m_gen[int'(req_addr) - int'(CSR_BASE)] = m_new;
          else case (req_addr)
            12'hB00: cyc_n = {m_cyc[63:32], m_new};
            12'hB80: cyc_n = {m_new, m_cyc[31:0]};
            12'hB02: ins_n = {m_ins[63:32], m_new};
            default: ins_n = {m_new, m_ins[31:0]};
          endcase
        end
      end
      m_cyc = cyc_n;
      m_ins = ins_n;
    end
  end

  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      if (exp_valid) chk("rsp_illegal", 32'(rsp_illegal), 32'(exp_ill));
    end
  end

  task automatic do_req(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [4:0] z, input logic sz);
    req_valid = 1; req_addr = a; req_funct3 = f3; req_rs1_data = rs1; req_zimm = z;
    req_src_zero = sz;
    @(negedge clk);
    $display("[TB] req addr=%h f3=%b rs1=%h zimm=%h sz=%b ret=%b -> valid=%b rdata=%h ill=%b",
             a, f3, rs1, z, sz, retire, rsp_valid, rsp_rdata, rsp_illegal);
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  logic [11:0] cnt_tbl [8] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82,
                               12'hC00, 12'hC80, 12'hC02, 12'hC82};
  logic [11:0] bad_tbl [6] = '{12'h7C8, 12'h7BF, 12'hB01, 12'hC01, 12'hB03, 12'hB81};

  initial begin
    logic [11:0] a;
    logic [2:0]  f3;
    logic        sz;

    repeat (2) @(negedge clk);
    rst_n = 1;
    started = 1;
    chk("reset_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_illegal", 32'(rsp_illegal), 32'h0);

    do_req(12'h7C0, 3'b001, 32'hDEADBEEF, 5'd0, 1'b0);
    chk("rw_first", rsp_rdata, 32'h0);
    do_req(12'h7C0, 3'b010, 32'h10, 5'd0, 1'b0);
    chk("rs_old", rsp_rdata, 32'hDEADBEEF);
    do_req(12'h7C0, 3'b010, 32'h0, 5'd0, 1'b1);
    chk("rs_result", rsp_rdata, 32'hDEADBEFF);

    do_req(12'h7C1, 3'b001, 32'hFF, 5'd0, 1'b0);
    do_req(12'h7C1, 3'b111, 32'h0, 5'h0F, 1'b0);
    chk("rci_old", rsp_rdata, 32'hFF);
    do_req(12'h7C1, 3'b110, 32'h0, 5'h00, 1'b1);
    chk("rsi_zero_read", rsp_rdata, 32'hF0);
    do_req(12'h7C1, 3'b111, 32'h0, 5'h1F, 1'b0);
    chk("rci_old2", rsp_rdata, 32'hF0);
    do_req(12'h7C1, 3'b010, 32'h0, 5'd0, 1'b1);
    chk("rci_result", rsp_rdata, 32'hE0);

    do_req(12'h7C0, 3'b100, 32'h1, 5'd0, 1'b0);
    chk("f3_100_ill", 32'(rsp_illegal), 32'h1);
    chk("f3_100_rdata", rsp_rdata, 32'h0);
    do_req(12'h7C8, 3'b001, 32'h5, 5'd0, 1'b0);
    chk("addr_7c8_ill", 32'(rsp_illegal), 32'h1);
    do_req(12'hC00, 3'b001, 32'h5, 5'd0, 1'b0);
    chk("ro_write_ill", 32'(rsp_illegal), 32'h1);
    do_req(12'hC00, 3'b010, 32'h0, 5'd0, 1'b1);
    chk("ro_read_legal", 32'(rsp_illegal), 32'h0);

    do_req(12'hB80, 3'b001, 32'h0, 5'd0, 1'b0);
    do_req(12'hB00, 3'b001, 32'hFFFFFFFF, 5'd0, 1'b0);
    idle(1);
    do_req(12'hB80, 3'b010, 32'h0, 5'd0, 1'b1);
    chk("mcycle_carry", rsp_rdata, 32'h1);

    do_req(12'hB82, 3'b001, 32'h0, 5'd0, 1'b0);
    do_req(12'hB02, 3'b001, 32'h0, 5'd0, 1'b0);
    retire = 1;
    idle(5);
    retire = 0;
    do_req(12'hC02, 3'b010, 32'h0, 5'd0, 1'b1);
    chk("instret_5", rsp_rdata, 32'd5);

    retire = 1;
    do_req(12'hB02, 3'b001, 32'd100, 5'd0, 1'b0);
    chk("collide_old", rsp_rdata, 32'd5);
    do_req(12'hB02, 3'b010, 32'h0, 5'd0, 1'b1);
    chk("collide_100", rsp_rdata, 32'd100);
    do_req(12'hB02, 3'b010, 32'h0, 5'd0, 1'b1);
    chk("collide_101", rsp_rdata, 32'd101);
    retire = 0;

    for (int n = 0; n < 400; n++) begin
      retire = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        case ($urandom_range(0, 5))
          0, 1, 2: a = CSR_BASE + 12'($urandom_range(0, NUM_CSR - 1));
          3:       a = cnt_tbl[$urandom_range(0, 7)];
          4:       a = bad_tbl[$urandom_range(0, 5)];
          default: a = 12'($urandom);
        endcase
        f3 = 3'($urandom_range(0, 7));
        sz = ($urandom_range(0, 3) == 0);
        do_req(a, f3, sz ? 32'h0 : $urandom, sz ? 5'd0 : 5'($urandom_range(1, 31)), sz);
      end
    end
    retire = 0;

    do_req(12'h7C2, 3'b001, 32'h11111111, 5'd0, 1'b0);
    req_valid = 1; req_addr = 12'h7C3; req_funct3 = 3'b001;
    req_rs1_data = 32'h22222222; req_src_zero = 0;
    #2 rst_n = 0;
    #1;
    chk("async_valid", 32'(rsp_valid), 32'h0);
    chk("async_rdata", rsp_rdata, 32'h0);
    chk("async_illegal", 32'(rsp_illegal), 32'h0);
    req_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("no_dropped_rsp", 32'(rsp_valid), 32'h0);
    for (int i = 0; i < NUM_CSR; i++) begin
      do_req(CSR_BASE + 12'(i), 3'b010, 32'h0, 5'd0, 1'b1);
      chk("post_reset_csr", rsp_rdata, 32'h0);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
